// File: rtl/spi_slave.sv
// SPI slave (modes 0-3) that oversamples sck/mosi/ssn in the clk domain.
// Optional macro SPI_SLAVE_LSB_FIRST_EN: shift LSB first on miso and mosi.
module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] spcon,
  input  logic [7:0] data_s,
  output logic [7:0] data_r_s,
  output logic       rx_valid,
  output logic       busy,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ssn,
  output logic       miso
);
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state_reg, state_next;

  logic [2:0] sck_sync, mosi_sync;
  logic [1:0] ssn_sync;
  logic       cpol_reg, cpha_reg;
  logic       lead_reg, trail_reg;
  logic [7:0] tx_shift, rx_shift;
  logic [2:0] bit_cnt;
  logic       miso_reg;

  logic       sck_toggle, lead_edge, trail_edge;
  logic       entering, staying, sample_now, shift_now;
  logic [7:0] rx_byte, load_rest, tx_rest;
  logic       load_bit, tx_bit;
  logic       spcon_unused;

  assign spcon_unused = ^spcon[7:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 3'b000;
      mosi_sync <= 3'b000;
      ssn_sync  <= 2'b11;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      mosi_sync <= {mosi_sync[1:0], mosi};
      ssn_sync  <= {ssn_sync[0], ssn};
    end
  end

  // Edge polarity is judged against the CPOL latched at select time.
  assign sck_toggle = sck_sync[1] ^ sck_sync[2];
  assign lead_edge  = sck_toggle && (sck_sync[2] == cpol_reg);
  assign trail_edge = sck_toggle && (sck_sync[1] == cpol_reg);

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_byte   = {mosi_sync[2], rx_shift[7:1]};
  assign load_bit  = data_s[0];
  assign load_rest = {1'b0, data_s[7:1]};
  assign tx_bit    = tx_shift[0];
  assign tx_rest   = {1'b0, tx_shift[7:1]};
`else
  assign rx_byte   = {rx_shift[6:0], mosi_sync[2]};
  assign load_bit  = data_s[7];
  assign load_rest = {data_s[6:0], 1'b0};
  assign tx_bit    = tx_shift[7];
  assign tx_rest   = {tx_shift[6:0], 1'b0};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    entering   = 1'b0;
    staying    = 1'b0;
    sample_now = 1'b0;
    shift_now  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!ssn_sync[1] && spcon[0]) begin
          state_next = ACTIVE;
          entering   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssn_sync[1] || !spcon[0]) begin
          state_next = IDLE;
        end else begin
          staying    = 1'b1;
          sample_now = cpha_reg ? trail_reg : lead_reg;
          shift_now  = cpha_reg ? lead_reg : trail_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_reg  <= 1'b0;
      cpha_reg  <= 1'b0;
      lead_reg  <= 1'b0;
      trail_reg <= 1'b0;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      bit_cnt   <= 3'd0;
      miso_reg  <= 1'b0;
      data_r_s  <= 8'h00;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      lead_reg  <= staying && lead_edge;
      trail_reg <= staying && trail_edge;
      if (entering) begin
        cpol_reg <= spcon[2];
        cpha_reg <= spcon[1];
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        // CPHA=0 must drive the first bit before any sck edge arrives.
        if (spcon[1]) begin
          tx_shift <= data_s;
          miso_reg <= 1'b0;
        end else begin
          tx_shift <= load_rest;
          miso_reg <= load_bit;
        end
      end else if (!staying) begin
        tx_shift <= 8'h00;
        rx_shift <= 8'h00;
        bit_cnt  <= 3'd0;
        miso_reg <= 1'b0;
      end else begin
        if (sample_now) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte;
          if (bit_cnt == 3'd7) begin
            data_r_s <= rx_byte;
            rx_valid <= 1'b1;
            tx_shift <= data_s;
          end
        end
        if (shift_now) begin
          miso_reg <= tx_bit;
          tx_shift <= tx_rest;
        end
      end
    end
  end

  assign busy = (state_reg == ACTIVE);
  assign miso = miso_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized SPI master around spi_slave; a scoreboard queue checks received
// bytes and rx_valid timing, the master side checks the bytes seen on miso.
`timescale 1ns/1ps
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] spcon = 8'h00;
  logic [7:0] data_s = 8'h00;
  logic [7:0] data_r_s;
  logic       rx_valid, busy, miso;
  logic       sck = 1'b0, mosi = 1'b0, ssn = 1'b1;

  spi_slave dut (
    .clk(clk), .rst(rst), .spcon(spcon), .data_s(data_s),
    .data_r_s(data_r_s), .rx_valid(rx_valid), .busy(busy),
    .sck(sck), .mosi(mosi), .ssn(ssn), .miso(miso)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_data_q[$];
  int         exp_cyc_q[$];
  logic [7:0] last_rx = 8'h00;
  int         half = 4;
  logic       cpol_m = 1'b0, cpha_m = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else
      $display("ok   %s: %02h", name, act);
  endtask

  // Monitor: every rx_valid must match the oldest expected byte and cycle.
  initial begin
    logic       rxv_prev;
    logic [7:0] ed;
    int         ec;
    rxv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && rx_valid) begin
        total++;
        if (rxv_prev) begin
          bad++;
          $display("FAIL rx_valid_width: got 2+ cycles expected 1");
        end
        if (exp_data_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rx_valid: got data %02h expected no pulse", data_r_s);
        end else begin
          ed = exp_data_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("rx_data", data_r_s, ed);
          total++;
          if (cyc != ec) begin
            bad++;
            $display("FAIL rx_latency: got cycle %0d expected %0d", cyc, ec);
          end
        end
      end
      rxv_prev = rx_valid;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] shift_in(input logic [7:0] r, input logic m);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return {m, r[7:1]};
`else
    return {r[6:0], m};
`endif
  endfunction

  task automatic push_expected(input logic [7:0] b);
    exp_data_q.push_back(b);
    exp_cyc_q.push_back(cyc + 4);
    last_rx = b;
  endtask

  task automatic select_slave(input logic [7:0] mode);
    spcon  = mode;
    cpol_m = mode[2];
    cpha_m = mode[1];
    sck    = mode[2];
    wclk(4);
    ssn = 1'b0;
    wclk(half + 2);
  endtask

  task automatic deselect_slave();
    wclk(half);
    ssn = 1'b1;
    wclk(6);
  endtask

  // Shift nbits of tx out on mosi; optionally swap data_s mid-byte.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit chg,
                      input logic [7:0] next_ds, output logic [7:0] rx);
    logic b;
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
      b = tx[i];
`else
      b = tx[7-i];
`endif
      if (chg && i == 3) data_s = next_ds;
      if (!cpha_m) begin
        mosi = b;
        wclk(half);
        rx  = shift_in(rx, miso);
        sck = ~cpol_m;
        if (i == 7) push_expected(tx);
        wclk(half);
        sck = cpol_m;
      end else begin
        wclk(half);
        sck  = ~cpol_m;
        mosi = b;
        wclk(half);
        rx  = shift_in(rx, miso);
        sck = cpol_m;
        if (i == 7) push_expected(tx);
      end
    end
  endtask

  initial begin
    logic [7:0] r, r2, mode, tx, nds, ds;
    int nbytes;

    rst = 1'b1;
    wclk(3);
    check("reset_data_r_s", data_r_s, 8'h00);
    check("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_miso", {7'd0, miso}, 8'h00);
    rst = 1'b0;
    wclk(3);

    // Mode 0 reference transfer.
    half = 4;
    data_s = 8'hA5;
    select_slave(8'h01);
    check("mode0_busy", {7'd0, busy}, 8'h01);
    xfer(8'h3C, 8, 1'b0, 8'h00, r);
    check("mode0_miso_byte", r, 8'hA5);
    deselect_slave();
    check("mode0_data_hold", data_r_s, 8'h3C);

    // Modes 1..3.
    for (int m = 1; m < 4; m++) begin
      mode = 8'h01 | 8'(m << 1);
      data_s = 8'h0F;
      select_slave(mode);
      xfer(8'h96, 8, 1'b0, 8'h00, r);
      check($sformatf("mode%0d_miso_byte", m), r, 8'h0F);
      deselect_slave();
      check($sformatf("mode%0d_data", m), data_r_s, 8'h96);
    end

    // Back-to-back bytes, data_s swapped during the first.
    data_s = 8'hC3;
    select_slave(8'h01);
    xfer(8'h11, 8, 1'b1, 8'h55, r);
    xfer(8'hEE, 8, 1'b0, 8'h00, r2);
    check("b2b_miso_first", r, 8'hC3);
    check("b2b_miso_second", r2, 8'h55);
    deselect_slave();

    // Abort after 5 bits, then a clean byte.
    data_s = 8'h3A;
    select_slave(8'h01);
    xfer(8'hF0, 5, 1'b0, 8'h00, r);
    deselect_slave();
    check("abort_busy", {7'd0, busy}, 8'h00);
    check("abort_miso", {7'd0, miso}, 8'h00);
    check("abort_data_hold", data_r_s, last_rx);
    data_s = 8'h24;
    select_slave(8'h01);
    xfer(8'h81, 8, 1'b0, 8'h00, r);
    check("after_abort_miso", r, 8'h24);
    deselect_slave();
    check("after_abort_data", data_r_s, 8'h81);

    // Reset mid-byte, then stay disabled with ssn low.
    select_slave(8'h01);
    xfer(8'h5A, 4, 1'b0, 8'h00, r);
    rst = 1'b1;
    wclk(1);
    check("midrst_data_r_s", data_r_s, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    check("midrst_miso", {7'd0, miso}, 8'h00);
    check("midrst_rx_valid", {7'd0, rx_valid}, 8'h00);
    spcon = 8'h00;
    sck = 1'b0;
    wclk(2);
    rst = 1'b0;
    last_rx = 8'h00;
    for (int i = 0; i < 12; i++) begin
      wclk(1);
      check("disabled_busy", {7'd0, busy}, 8'h00);
    end
    check("disabled_data", data_r_s, 8'h00);
    ssn = 1'b1;
    wclk(6);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    data_s = 8'h01;
    select_slave(8'h01);
    xfer(8'h01, 8, 1'b0, 8'h00, r);
    check("lsb_first_miso_bit", {7'd0, r[0]}, 8'h01);
    check("lsb_miso_byte", r, 8'h01);
    deselect_slave();
    check("lsb_data", data_r_s, 8'h01);
`endif

    // Randomized modes, speeds, burst lengths and data.
    for (int t = 0; t < 12; t++) begin
      mode   = 8'($urandom_range(0, 255)) | 8'h01;
      half   = $urandom_range(4, 6);
      ds     = 8'($urandom_range(0, 255));
      nbytes = $urandom_range(1, 3);
      data_s = ds;
      select_slave(mode);
      for (int k = 0; k < nbytes; k++) begin
        tx  = 8'($urandom_range(0, 255));
        nds = 8'($urandom_range(0, 255));
        xfer(tx, 8, 1'b1, nds, r);
        check($sformatf("rand%0d_byte%0d_miso", t, k), r, ds);
        ds = nds;
      end
      deselect_slave();
      check($sformatf("rand%0d_data", t), data_r_s, last_rx);
    end

    wclk(10);
    check("scoreboard_empty", 8'(exp_data_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 spcon  input  8  control: bit0 SPE (enable), bit1 CPHA, bit2 CPOL, bits7:3 ignored.
REQ-004 data_s  input  8  byte to transmit; captured at each byte start.
REQ-005 data_r_s  output  8  last complete received byte.
REQ-006 rx_valid  output  1  one-clk pulse when data_r_s updates.
REQ-007 busy  output  1  high while selected and enabled (ACTIVE state).
REQ-008 sck  input  1  serial clock from master, asynchronous to clk.
REQ-009 mosi  input  1  serial data from master.
REQ-010 ssn  input  1  active-low slave select from master.
REQ-011 miso  output  1  serial data to master.

Function
REQ-012 sck, mosi and ssn SHALL each pass through a 2-flop synchronizer; sck gets a third flop for edge detection, and mosi is delayed to stay aligned with synchronized sck.
REQ-013 Supported sck: high and low phases each >= 3 clk periods; faster sck is out of scope.
REQ-014 Leading edge = synchronized sck leaving CPOL level; trailing edge = returning to CPOL level.
REQ-015 States: IDLE, ACTIVE; IDLE->ACTIVE when synchronized ssn=0 and SPE=1; ACTIVE->IDLE when synchronized ssn=1 or SPE=0.
REQ-016 On IDLE->ACTIVE: tx shift register loads data_s, bit counter = 0.
REQ-017 CPHA=0: miso presents tx bit 7 upon entering ACTIVE; sample mosi on leading edge; shift tx on trailing edge.
REQ-018 CPHA=1: shift out next tx bit on leading edge (first leading edge presents bit 7); sample mosi on trailing edge.
REQ-019 Bits SHALL be MSB first; bit counter 3 bits, increments per sample, wraps 7->0.
REQ-020 On 8th sample: data_r_s <= assembled byte, rx_valid = 1 for exactly one clk, tx shift register reloads data_s for back-to-back bytes without deselect.
REQ-021 rx_valid SHALL assert on the 3rd clk rising edge after the clk edge that first samples the new raw sck level.
REQ-022 miso SHALL be 0 in IDLE.
REQ-023 Deselect or SPE=0 mid-byte: abort, bit counter = 0, no rx_valid, data_r_s unchanged.
REQ-024 spcon changes are honoured only in IDLE; CPOL/CPHA are latched on IDLE->ACTIVE.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, data_r_s=8'h00, rx_valid=0, busy=0, miso=0, counters and shift registers 0, synchronizer flops to idle (ssn flops 1, sck flops 0).
REQ-026 Reset asserted mid-byte SHALL discard the partial byte; after release, a fresh select is required to start.

Configuration
REQ-027 Macro SPI_SLAVE_LSB_FIRST_EN: defined -> transmit and receive LSB first (miso presents tx bit 0 first; first sampled mosi bit -> data_r_s[0]); undefined -> MSB first per REQ-019.

Verification
REQ-028 Mode0 (spcon=8'h01), data_s=8'hA5, master sends 8'h3C, sck half-period 4 clk -> miso stream 1,0,1,0,0,1,0,1; data_r_s=8'h3C; one rx_valid pulse.
REQ-029 Modes 1, 2, 3 (spcon=8'h03, 8'h05, 8'h07), master sends 8'h96, data_s=8'h0F -> data_r_s=8'h96, master receives 8'h0F in each mode.
REQ-030 Two back-to-back bytes 8'h11, 8'hEE without deassert, data_s changed to 8'h55 between -> two rx_valid pulses, data_r_s 8'h11 then 8'hEE; second tx byte 8'h55.
REQ-031 ssn deasserted after 5 bits -> no rx_valid, data_r_s keeps previous value, busy=0, miso=0; next full byte 8'h81 received correctly.
REQ-032 rst pulsed mid-byte, then spcon=8'h00 with ssn low -> all outputs at reset values, busy stays 0, no rx_valid.
REQ-033 With SPI_SLAVE_LSB_FIRST_EN, data_s=8'h01, master sends bits 1,0,0,0,0,0,0,0 in time order -> first miso bit 1, data_r_s=8'h01.
